uart_ctrl_fifo: RTL and testbench
=================================

# uart_ctrl_fifo

Parametrised successor to the single-byte UART bus controller. It sits between the processor's chip-select bus and the `uart_rx`/`uart_tx` serial engines. It adds RX and TX FIFOs of configurable depth, a control register, threshold-driven level interrupts, and overrun and drop detection. A TX sequencer drains the TX FIFO into the transmitter without CPU involvement per byte.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: entries per FIFO. Must be a power of two, 2..128.
- `PTR_W`, default 3: log2(`FIFO_DEPTH`). Count width is `PTR_W+1`.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `cs_` input 1: chip select, active low.
- `as_` input 1: address strobe, active low.
- `rw` input 1: `READ`/`WRITE`.
- `addr` input 30: word address. Only `addr[1:0]` is decoded: 0 STATUS, 1 DATA, 2 CTRL, 3 reserved (reads 0, writes ignored).
- `wr_data` input 32: write data.
- `rd_data` output 32: read data, registered.
- `rdy_` output 1: access acknowledge, active low.
- `irq_rx` output 1: RX level interrupt.
- `irq_tx` output 1: TX-empty interrupt.
- `rx_busy`, `rx_end` input 1 each; `rx_data` input 8: from the receiver.
- `tx_busy`, `tx_end` input 1 each: from the transmitter.
- `tx_start` output 1; `tx_data` output 8: to the transmitter.

## Operation
- **Access detection.** An access is any cycle with `cs_` and `as_` both low. The *first* cycle of an access is one where `rdy_` is currently high. Side effects (pop, push, register write) happen only on the first cycle.
- **STATUS read layout:**
  - [0] `irq_rx`, [1] `irq_tx`, [2] `rx_busy`, [3] `tx_busy`
  - [4] rx_empty, [5] rx_full, [6] tx_empty, [7] tx_full
  - [8] rx_overrun, [9] tx_drop
  - [23:16] rx_count, zero-extended
  - [31:24] tx_count, zero-extended
- **STATUS write.** Bits [8] and [9] are write-1-to-clear. All other bits are ignored.
- **CTRL read/write layout:**
  - [0] rx_irq_en, [1] tx_irq_en
  - [15:8] rx_thresh. A value of 0 is treated as 1.
  - [16] loopback (only when configured)
  - [17] flush_rx, [18] flush_tx. These are self-clearing strobes and always read 0.
- **DATA read.** Returns the RX FIFO head in bits [7:0] and pops it. If the RX FIFO is empty, it returns 0 and pops nothing.
- **DATA write.** Pushes `wr_data[7:0]` into the TX FIFO. If the TX FIFO is full, the byte is discarded and tx_drop is set.
- **RX push.** `rx_end` pushes `rx_data`. If the RX FIFO is full and no pop occurs the same cycle, the byte is discarded and rx_overrun is set.
- **Simultaneous push and pop** on the same FIFO: both happen, and the count is unchanged. This includes push-on-full and pop-on-empty (a no-op pop).
- **Flush** resets pointers and count to 0. Flush wins over a same-cycle push or pop.
- **TX sequencer FSM:**
  - IDLE → LOAD when TX FIFO is non-empty and `tx_busy`=0.
  - LOAD: pops the head into `tx_data` and pulses `tx_start` for 1 cycle; → WAIT.
  - WAIT → IDLE on `tx_end`.
  - flush_tx does not abort a byte in WAIT.
- **Interrupts:**
  - `irq_rx` = rx_irq_en & (rx_count ≥ rx_thresh).
  - `irq_tx` = tx_irq_en & tx_empty & FSM in IDLE.
  - Both are level signals, registered, and clear by servicing the condition or clearing the enable.

## Timing
- **Reset values:**
  - `rd_data`=0, `rdy_`=1, `irq_rx`=`irq_tx`=0, `tx_start`=0, `tx_data`=0.
  - FIFOs empty, sticky flags 0, CTRL=0 (effective threshold 1).
  - FSM in IDLE.
- **Reset mid-operation:** reset mid-frame returns the FSM to IDLE. Any byte already handed to the transmitter is not tracked.
- **Bus timing:**
  - `rdy_` goes low the cycle after the access appears and stays low while it persists.
  - `rd_data` is valid in the same cycle as `rdy_` low, and is 0 otherwise.
- **Read-after-write:** a write followed by a read of the same register returns the new value.
- **TX latency:** from a DATA write into an empty FIFO with the transmitter idle, `tx_start` is asserted 2 cycles after the write's first cycle (cycle 1 IDLE→LOAD, cycle 2 pulse).
- **RX latency:** a byte arriving on `rx_end` at cycle N is counted, and `irq_rx` reflects it, at N+2.

## Configuration
- **`UART_CTRL_LOOPBACK_EN`** defined:
  - CTRL[16] is implemented.
  - When it is set, the LOAD-cycle byte is pushed into the RX FIFO instead of pulsing `tx_start`. The FSM goes LOAD → IDLE directly, and `rx_end` pushes are ignored.
- **Undefined:** CTRL[16] reads 0 and the logic is absent.

## Structure
- **Shared package** (`uart.h` additions):
  - `UART_ADDR_CTRL`
  - STATUS/CTRL bit-index constants
  - FSM state encodings `UART_TX_IDLE`/`LOAD`/`WAIT`
- **Sub-module:** `uart_fifo` (parameters `FIFO_DEPTH`, `PTR_W`; push/pop/flush; head, count, empty, full). It is instantiated twice.

## Test plan
- **Burst TX:** write 0x41, 0x42, 0x43 to DATA with `tx_end` returned 20 cycles after each `tx_start`. Expect `tx_data` to sequence 0x41, 0x42, 0x43, and `irq_tx`=1 (tx_irq_en=1) only after the final `tx_end`.
- **RX threshold:** set rx_thresh=3 and rx_irq_en=1, then deliver 3 `rx_end` bytes. Expect `irq_rx` to rise 2 cycles after the third byte, then fall after one DATA read (count 2).
- **RX overrun:** fill the RX FIFO with 8 bytes, then send a 9th. Expect rx_overrun=1, rx_count=8, and the head still equal to the first byte. Writing 0x100 to STATUS clears the flag.
- **Simultaneous push/pop when full:** `rx_end` coincides with the first cycle of a DATA read. Expect the read to return the oldest byte, rx_count to stay 8, and rx_overrun to stay 0.
- **TX full drop and flush:** with `tx_busy` held high, perform 9 DATA writes. Expect tx_drop=1 and tx_count=8. Writing CTRL bit 18 then gives tx_count=0 and no `tx_start`.
- **Loopback (macro defined):** set CTRL[16] and write 0x5A. Expect `tx_start` to stay low, and a DATA read 4 cycles later to return 0x5A.

Source files
------------

// File: rtl/uart_ctrl_fifo_pkg.sv
// Shared register map, bit indices and TX sequencer states for uart_ctrl_fifo.
// Pure declarations: no logic, no latency, no flow control.
package uart_ctrl_fifo_pkg;

  localparam logic UART_READ  = 1'b1;
  localparam logic UART_WRITE = 1'b0;

  localparam logic [1:0] UART_ADDR_STATUS = 2'd0;
  localparam logic [1:0] UART_ADDR_DATA   = 2'd1;
  localparam logic [1:0] UART_ADDR_CTRL   = 2'd2;

  localparam int STAT_IRQ_RX     = 0;
  localparam int STAT_IRQ_TX     = 1;
  localparam int STAT_RX_BUSY    = 2;
  localparam int STAT_TX_BUSY    = 3;
  localparam int STAT_RX_EMPTY   = 4;
  localparam int STAT_RX_FULL    = 5;
  localparam int STAT_TX_EMPTY   = 6;
  localparam int STAT_TX_FULL    = 7;
  localparam int STAT_RX_OVERRUN = 8;
  localparam int STAT_TX_DROP    = 9;
  localparam int STAT_RX_CNT_LSB = 16;
  localparam int STAT_TX_CNT_LSB = 24;

  localparam int CTRL_RX_IRQ_EN  = 0;
  localparam int CTRL_TX_IRQ_EN  = 1;
  localparam int CTRL_THRESH_LSB = 8;
  localparam int CTRL_LOOPBACK   = 16;
  localparam int CTRL_FLUSH_RX   = 17;
  localparam int CTRL_FLUSH_TX   = 18;

  typedef enum logic [1:0] {
    UART_TX_IDLE = 2'd0,
    UART_TX_LOAD = 2'd1,
    UART_TX_WAIT = 2'd2
  } tx_state_e;

  // A programmed threshold of zero behaves as one.
  function automatic logic [7:0] eff_thresh(input logic [7:0] t);
    return (t == 8'd0) ? 8'd1 : t;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with push/pop/flush; head is combinational, count updates one cycle after push/pop.
// Push on full is dropped unless a pop lands the same cycle; pop on empty is a no-op; flush wins.
module uart_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_W      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [7:0]       push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [7:0]       head,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full
);

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             pop_eff, push_eff;

  assign empty = (count_q == '0);
  assign full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    pop_eff  = pop & ~empty & ~flush;
    push_eff = push & (~full | pop_eff) & ~flush;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_eff)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + (PTR_W+1)'(push_eff) - (PTR_W+1)'(pop_eff);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; empty/full are decided by count alone.
  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/uart_ctrl_fifo.sv
// Chip-select UART controller: RX/TX FIFOs, CTRL, level IRQs, TX sequencer; rdy_/rd_data one cycle after access.
// TX waits on tx_busy, full FIFOs drop and flag; UART_CTRL_LOOPBACK_EN adds CTRL[16] TX->RX loopback.
module uart_ctrl_fifo
  import uart_ctrl_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_W      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_,
  input  logic        as_,
  input  logic        rw,
  input  logic [29:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rdy_,
  output logic        irq_rx,
  output logic        irq_tx,
  input  logic        rx_busy,
  input  logic        rx_end,
  input  logic [7:0]  rx_data,
  input  logic        tx_busy,
  input  logic        tx_end,
  output logic        tx_start,
  output logic [7:0]  tx_data
);

  logic        access, first, is_rd, is_wr, lb_on, unused_bits;
  logic [1:0]  reg_sel;
  logic [31:0] status_word, ctrl_word, rd_mux;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rdy_q, rdy_d;
  logic        rx_irq_en_q, rx_irq_en_d, tx_irq_en_q, tx_irq_en_d;
  logic [7:0]  rx_thresh_q, rx_thresh_d;
  logic        rx_overrun_q, rx_overrun_d, tx_drop_q, tx_drop_d;
  logic        irq_rx_q, irq_rx_d, irq_tx_q, irq_tx_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  tx_state_e   state_q, state_d;

  logic             rx_push, rx_pop, rx_flush, rx_empty, rx_full;
  logic             tx_push, tx_pop, tx_flush, tx_empty, tx_full;
  logic [7:0]       rx_push_dat, rx_head, tx_head;
  logic [PTR_W:0]   rx_count, tx_count;

`ifdef UART_CTRL_LOOPBACK_EN
  logic loopback_q, loopback_d;
  assign lb_on       = loopback_q;
  assign unused_bits = ^{addr[29:2], wr_data[31:19]};
`else
  assign lb_on       = 1'b0;
  assign unused_bits = ^{addr[29:2], wr_data[31:19], wr_data[CTRL_LOOPBACK]};
`endif

  assign access  = ~cs_ & ~as_;
  assign first   = access & rdy_q;
  assign is_rd   = (rw == UART_READ);
  assign is_wr   = (rw == UART_WRITE);
  assign reg_sel = addr[1:0];

  uart_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .push_dat(rx_push_dat), .pop(rx_pop),
    .flush(rx_flush), .head(rx_head), .count(rx_count), .empty(rx_empty), .full(rx_full)
  );

  uart_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .push_dat(wr_data[7:0]), .pop(tx_pop),
    .flush(tx_flush), .head(tx_head), .count(tx_count), .empty(tx_empty), .full(tx_full)
  );

  always_comb begin
    status_word = '0;
    status_word[STAT_IRQ_RX]     = irq_rx_q;
    status_word[STAT_IRQ_TX]     = irq_tx_q;
    status_word[STAT_RX_BUSY]    = rx_busy;
    status_word[STAT_TX_BUSY]    = tx_busy;
    status_word[STAT_RX_EMPTY]   = rx_empty;
    status_word[STAT_RX_FULL]    = rx_full;
    status_word[STAT_TX_EMPTY]   = tx_empty;
    status_word[STAT_TX_FULL]    = tx_full;
    status_word[STAT_RX_OVERRUN] = rx_overrun_q;
    status_word[STAT_TX_DROP]    = tx_drop_q;
    status_word[STAT_RX_CNT_LSB +: 8] = 8'(rx_count);
    status_word[STAT_TX_CNT_LSB +: 8] = 8'(tx_count);
    ctrl_word = '0;
    ctrl_word[CTRL_RX_IRQ_EN] = rx_irq_en_q;
    ctrl_word[CTRL_TX_IRQ_EN] = tx_irq_en_q;
    ctrl_word[CTRL_THRESH_LSB +: 8] = rx_thresh_q;
`ifdef UART_CTRL_LOOPBACK_EN
    ctrl_word[CTRL_LOOPBACK] = loopback_q;
`endif
    case (reg_sel)
      UART_ADDR_STATUS: rd_mux = status_word;
      UART_ADDR_DATA:   rd_mux = rx_empty ? 32'd0 : {24'd0, rx_head};
      UART_ADDR_CTRL:   rd_mux = ctrl_word;
      default:          rd_mux = '0;
    endcase
  end

  always_comb begin
    rd_data_d    = '0;
    rdy_d        = ~access;
    rx_irq_en_d  = rx_irq_en_q;
    tx_irq_en_d  = tx_irq_en_q;
    rx_thresh_d  = rx_thresh_q;
`ifdef UART_CTRL_LOOPBACK_EN
    loopback_d   = loopback_q;
`endif
    rx_overrun_d = rx_overrun_q;
    tx_drop_d    = tx_drop_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    state_d      = state_q;
    rx_pop       = 1'b0;
    tx_pop       = 1'b0;
    tx_push      = 1'b0;
    rx_flush     = 1'b0;
    tx_flush     = 1'b0;

    // Read data is captured on the first cycle and held while the access persists.
    if (access && is_rd) rd_data_d = first ? rd_mux : rd_data_q;
    if (first && is_rd && reg_sel == UART_ADDR_DATA) rx_pop = 1'b1;

    if (first && is_wr) begin
      case (reg_sel)
        UART_ADDR_STATUS: begin
          if (wr_data[STAT_RX_OVERRUN]) rx_overrun_d = 1'b0;
          if (wr_data[STAT_TX_DROP])    tx_drop_d    = 1'b0;
        end
        UART_ADDR_DATA: tx_push = 1'b1;
        UART_ADDR_CTRL: begin
          rx_irq_en_d = wr_data[CTRL_RX_IRQ_EN];
          tx_irq_en_d = wr_data[CTRL_TX_IRQ_EN];
          rx_thresh_d = wr_data[CTRL_THRESH_LSB +: 8];
`ifdef UART_CTRL_LOOPBACK_EN
          loopback_d  = wr_data[CTRL_LOOPBACK];
`endif
          rx_flush    = wr_data[CTRL_FLUSH_RX];
          tx_flush    = wr_data[CTRL_FLUSH_TX];
        end
        default: ;
      endcase
    end

    // tx_start/tx_data are registered on the IDLE->LOAD edge so the pulse lands in the LOAD cycle.
    case (state_q)
      UART_TX_IDLE: if (!tx_empty && !tx_busy) begin
        state_d = UART_TX_LOAD;
        if (!lb_on) begin
          tx_start_d = 1'b1;
          tx_data_d  = tx_head;
        end
      end
      UART_TX_LOAD: begin
        tx_pop  = 1'b1;
        state_d = lb_on ? UART_TX_IDLE : UART_TX_WAIT;
      end
      UART_TX_WAIT: if (tx_end) state_d = UART_TX_IDLE;
      default: state_d = UART_TX_IDLE;
    endcase

    rx_push     = lb_on ? (state_q == UART_TX_LOAD) : rx_end;
    rx_push_dat = lb_on ? tx_head : rx_data;

    // A new event outranks a same-cycle write-1-to-clear.
    if (rx_push && rx_full && !rx_pop && !rx_flush) rx_overrun_d = 1'b1;
    if (tx_push && tx_full && !tx_pop && !tx_flush) tx_drop_d = 1'b1;

    irq_rx_d = rx_irq_en_q & (8'(rx_count) >= eff_thresh(rx_thresh_q));
    irq_tx_d = tx_irq_en_q & tx_empty & (state_q == UART_TX_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q    <= '0;
      rdy_q        <= 1'b1;
      rx_irq_en_q  <= 1'b0;
      tx_irq_en_q  <= 1'b0;
      rx_thresh_q  <= '0;
`ifdef UART_CTRL_LOOPBACK_EN
      loopback_q   <= 1'b0;
`endif
      rx_overrun_q <= 1'b0;
      tx_drop_q    <= 1'b0;
      irq_rx_q     <= 1'b0;
      irq_tx_q     <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      state_q      <= UART_TX_IDLE;
    end else begin
      rd_data_q    <= rd_data_d;
      rdy_q        <= rdy_d;
      rx_irq_en_q  <= rx_irq_en_d;
      tx_irq_en_q  <= tx_irq_en_d;
      rx_thresh_q  <= rx_thresh_d;
`ifdef UART_CTRL_LOOPBACK_EN
      loopback_q   <= loopback_d;
`endif
      rx_overrun_q <= rx_overrun_d;
      tx_drop_q    <= tx_drop_d;
      irq_rx_q     <= irq_rx_d;
      irq_tx_q     <= irq_tx_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      state_q      <= state_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rdy_     = rdy_q;
  assign irq_rx   = irq_rx_q;
  assign irq_tx   = irq_tx_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_ctrl_fifo.sv
// Bench for uart_ctrl_fifo: register vector table, TX byte scoreboard fed by DATA writes,
// RX byte scoreboard fed by rx_end, and hand sequences for the multi-cycle corner cases.
module tb_uart_ctrl_fifo;
  import uart_ctrl_fifo_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs_ = 1'b1, as_ = 1'b1, rw = 1'b1;
  logic [29:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        rdy_, irq_rx, irq_tx;
  logic        rx_busy = 1'b0, rx_end = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        tx_busy = 1'b0, tx_end = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;

  int total = 0;
  int bad = 0;
  int tx_start_cnt = 0;
  int tx_end_cnt = 0;
  int tx_left = 0;
  logic hold_busy = 1'b0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  uart_ctrl_fifo #(.FIFO_DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_), .irq_rx(irq_rx), .irq_tx(irq_tx),
    .rx_busy(rx_busy), .rx_end(rx_end), .rx_data(rx_data), .tx_busy(tx_busy),
    .tx_end(tx_end), .tx_start(tx_start), .tx_data(tx_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Transmitter model plus TX scoreboard: tx_end comes 20 cycles after each tx_start.
  always @(negedge clk) begin
    tx_end = 1'b0;
    if (!reset && tx_start === 1'b1) begin
      tx_start_cnt++;
      if (tx_q.size() == 0) check("unexpected tx_start", 32'd1, 32'd0);
      else check("tx_data", {24'd0, tx_data}, {24'd0, tx_q.pop_front()});
      tx_left = 20;
    end else if (tx_left != 0) begin
      tx_left--;
      if (tx_left == 0) begin
        tx_end = 1'b1;
        tx_end_cnt++;
      end
    end
    tx_busy = hold_busy || (tx_left != 0);
  end

  task automatic bus_access(input logic [1:0] a, input logic r, input logic [31:0] wd,
                            output logic [31:0] rdat);
    int n;
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0; rw = r; addr = {28'd0, a}; wr_data = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rdy_ !== 1'b0 && n < 8);
    check("rdy_ ack", {31'd0, rdy_}, 32'd0);
    rdat = rd_data;
    cs_ = 1'b1; as_ = 1'b1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] wd);
    logic [31:0] d;
    bus_access(a, UART_WRITE, wd, d);
  endtask

  task automatic bus_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_access(a, UART_READ, 32'd0, d);
    check(name, d, exp);
  endtask

  task automatic data_rd();
    logic [7:0] e;
    e = (rx_q.size() == 0) ? 8'h00 : rx_q.pop_front();
    bus_rd("data read", UART_ADDR_DATA, {24'd0, e});
  endtask

  task automatic rx_byte(input logic [7:0] d, input bit expect_keep);
    @(negedge clk);
    rx_end = 1'b1; rx_data = d;
    if (expect_keep) rx_q.push_back(d);
    @(negedge clk);
    rx_end = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  a;
    logic        rd;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 15;
  vec_t vt[NV];

  initial begin
    logic [31:0] exp_ctrl;
    logic [7:0]  e;
    int n;
    int starts;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset rd_data", rd_data, 32'd0);
    check("reset rdy_", {31'd0, rdy_}, 32'd1);
    check("reset irqs", {30'd0, irq_tx, irq_rx}, 32'd0);
    check("reset tx_start", {31'd0, tx_start}, 32'd0);
    check("reset tx_data", {24'd0, tx_data}, 32'd0);
    reset = 1'b0;

`ifdef UART_CTRL_LOOPBACK_EN
    exp_ctrl = 32'h0001_0A03;
`else
    exp_ctrl = 32'h0000_0A03;
`endif
    vt[0]  = '{UART_ADDR_STATUS, 1'b1, 32'h0,          32'h0000_0050};
    vt[1]  = '{UART_ADDR_CTRL,   1'b1, 32'h0,          32'h0};
    vt[2]  = '{UART_ADDR_DATA,   1'b1, 32'h0,          32'h0};
    vt[3]  = '{2'd3,             1'b1, 32'h0,          32'h0};
    vt[4]  = '{UART_ADDR_CTRL,   1'b0, 32'h0007_0A03,  32'h0};
    vt[5]  = '{UART_ADDR_CTRL,   1'b1, 32'h0,          exp_ctrl};
    vt[6]  = '{UART_ADDR_STATUS, 1'b1, 32'h0,          32'h0000_0052};
    vt[7]  = '{UART_ADDR_CTRL,   1'b0, 32'h0000_0001,  32'h0};
    vt[8]  = '{UART_ADDR_STATUS, 1'b1, 32'h0,          32'h0000_0050};
    vt[9]  = '{UART_ADDR_CTRL,   1'b1, 32'h0,          32'h0000_0001};
    vt[10] = '{2'd3,             1'b0, 32'hFFFF_FFFF,  32'h0};
    vt[11] = '{2'd3,             1'b1, 32'h0,          32'h0};
    vt[12] = '{UART_ADDR_STATUS, 1'b0, 32'hFFFF_FFFF,  32'h0};
    vt[13] = '{UART_ADDR_STATUS, 1'b1, 32'h0,          32'h0000_0050};
    vt[14] = '{UART_ADDR_CTRL,   1'b0, 32'h0,          32'h0};
    for (int i = 0; i < NV; i++) begin
      if (vt[i].rd) bus_rd($sformatf("vec%0d", i), vt[i].a, vt[i].exp);
      else bus_wr(vt[i].a, vt[i].wd);
    end
    @(negedge clk);
    check("rd_data idle", rd_data, 32'd0);

    // Burst TX with tx_irq_en
    bus_wr(UART_ADDR_CTRL, 32'h2);
    tx_q.push_back(8'h41);
    bus_wr(UART_ADDR_DATA, 32'h41);
    check("tx_start latency-1", {31'd0, tx_start}, 32'd0);
    @(negedge clk);
    check("tx_start latency-2", {31'd0, tx_start}, 32'd1);
    tx_q.push_back(8'h42);
    bus_wr(UART_ADDR_DATA, 32'h42);
    tx_q.push_back(8'h43);
    bus_wr(UART_ADDR_DATA, 32'h43);
    check("irq_tx during burst", {31'd0, irq_tx}, 32'd0);
    n = 0;
    while (irq_tx !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("irq_tx rises", {31'd0, irq_tx}, 32'd1);
    check("irq_tx after last tx_end", tx_end_cnt, 3);
    check("burst tx_start count", tx_start_cnt, 3);
    bus_wr(UART_ADDR_CTRL, 32'h0);

    // RX threshold
    bus_wr(UART_ADDR_CTRL, 32'h0000_0301);
    rx_byte(8'hA1, 1'b1);
    rx_byte(8'hA2, 1'b1);
    rx_byte(8'hA3, 1'b1);
    check("irq_rx N+1", {31'd0, irq_rx}, 32'd0);
    @(negedge clk);
    check("irq_rx N+2", {31'd0, irq_rx}, 32'd1);
    data_rd();
    check("irq_rx held after pop", {31'd0, irq_rx}, 32'd1);
    @(negedge clk);
    check("irq_rx falls", {31'd0, irq_rx}, 32'd0);
    data_rd();
    data_rd();
    bus_wr(UART_ADDR_CTRL, 32'h0);

    // RX overrun
    for (int i = 0; i < 8; i++) rx_byte(8'h10 + 8'(i), 1'b1);
    rx_byte(8'hEE, 1'b0);
    bus_rd("status overrun", UART_ADDR_STATUS, 32'h0008_0160);
    bus_wr(UART_ADDR_STATUS, 32'h100);
    bus_rd("status overrun cleared", UART_ADDR_STATUS, 32'h0008_0060);

    // Push and pop together on a full RX FIFO
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0; rw = UART_READ; addr = {28'd0, UART_ADDR_DATA};
    rx_end = 1'b1; rx_data = 8'h99;
    e = rx_q.pop_front();
    rx_q.push_back(8'h99);
    @(negedge clk);
    rx_end = 1'b0;
    check("simul rdy_", {31'd0, rdy_}, 32'd0);
    check("simul oldest byte", rd_data, {24'd0, e});
    cs_ = 1'b1; as_ = 1'b1;
    bus_rd("status simul", UART_ADDR_STATUS, 32'h0008_0060);
    for (int i = 0; i < 9; i++) data_rd();
    bus_rd("status drained", UART_ADDR_STATUS, 32'h0000_0050);

    // TX full drop and flush
    hold_busy = 1'b1;
    repeat (2) @(negedge clk);
    starts = tx_start_cnt;
    for (int i = 0; i < 9; i++) bus_wr(UART_ADDR_DATA, 32'h60 + i);
    bus_rd("status tx full", UART_ADDR_STATUS, 32'h0800_0298);
    bus_wr(UART_ADDR_CTRL, 32'h0004_0000);
    bus_rd("status tx flushed", UART_ADDR_STATUS, 32'h0000_0258);
    bus_rd("ctrl flush reads 0", UART_ADDR_CTRL, 32'h0);
    hold_busy = 1'b0;
    repeat (10) @(negedge clk);
    check("no tx_start after flush", tx_start_cnt, starts);
    bus_wr(UART_ADDR_STATUS, 32'h200);
    bus_rd("status drop cleared", UART_ADDR_STATUS, 32'h0000_0050);

`ifdef UART_CTRL_LOOPBACK_EN
    bus_wr(UART_ADDR_CTRL, 32'h0001_0000);
    starts = tx_start_cnt;
    rx_q.push_back(8'h5A);
    bus_wr(UART_ADDR_DATA, 32'h5A);
    repeat (2) @(negedge clk);
    data_rd();
    check("loopback no tx_start", tx_start_cnt, starts);
    bus_wr(UART_ADDR_CTRL, 32'h0);
`else
    bus_wr(UART_ADDR_CTRL, 32'h0001_0000);
    bus_rd("ctrl loopback absent", UART_ADDR_CTRL, 32'h0);
`endif

    check("tx scoreboard empty", tx_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
